// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_pkg
// Brief   : Shared widths, stall encoding and hold-buffer states for IF.
// Revision: 1.0
// ============================================================================
package if_fetch_pkg;

    localparam int c_STALL_WD        = 6;
    localparam int c_BR_WD           = 33;
    localparam int c_IF_TO_ID_WD     = 33;

    localparam int c_STALL_IF        = 0;
    localparam int c_STALL_IFID      = 1;
    localparam int c_STALL_ID        = 2;

    localparam logic c_STOP          = 1'b1;
    localparam logic c_NO_STOP       = 1'b0;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'hBFBF_FFFC;

    typedef enum logic [0:0] {
        HB_PASS = 1'b0,
        HB_HOLD = 1'b1
    } hold_state_t;

endpackage : if_fetch_pkg
`default_nettype wire

// File: rtl/if_fetch_inst_hold_buf.sv
`default_nettype none
// ============================================================================
// Module  : inst_hold_buf
// Brief   : Keeps the SRAM read word stable for ID across ID stalls.
// Revision: 1.0
// ============================================================================
module inst_hold_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic [31:0] rdata_in,
    output logic [31:0] inst_out
);

    hold_state_t r_state;
    hold_state_t w_state_next;
    logic [31:0] r_hold;
    logic        w_capture;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        inst_out     = rdata_in;
        case (r_state)
            HB_PASS: begin
                inst_out = rdata_in;
                if (stall_id == c_STOP) begin
                    w_capture    = 1'b1;
                    w_state_next = HB_HOLD;
                end
            end
            HB_HOLD: begin
                // The release cycle still shows the held word; ID consumes it then.
                inst_out = r_hold;
                if (stall_id == c_NO_STOP) begin
                    w_state_next = HB_PASS;
                end
            end
            default: begin
                w_state_next = HB_PASS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HB_PASS;
            r_hold  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_hold <= rdata_in;
            end
        end
    end

endmodule : inst_hold_buf
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch
// Brief   : IF stage: PC register, next-PC select, inst SRAM port, hold buffer.
// Revision: 1.0
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [c_STALL_WD-1:0]    stall,
    input  logic [c_BR_WD-1:0]       br_bus,
    output logic [c_IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                     inst_sram_en,
    output logic [3:0]               inst_sram_wen,
    output logic [31:0]              inst_sram_addr,
    output logic [31:0]              inst_sram_wdata,
    input  logic [31:0]              inst_sram_rdata,
    output logic [31:0]              id_inst
);

    logic [31:0] r_pc;
    logic        r_ce;
    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic [31:0] w_next_pc;
    logic        w_unused_stall;

    assign w_br_e    = br_bus[32];
    assign w_br_addr = br_bus[31:0];
    // Delay slot is never flushed; a taken branch only redirects the PC.
    assign w_next_pc = w_br_e ? w_br_addr : (r_pc + 32'd4);

    assign w_unused_stall = ^{stall[c_STALL_WD-1:c_STALL_ID+1], stall[c_STALL_IFID]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_ce <= 1'b0;
        end else if (stall[c_STALL_IF] == c_NO_STOP) begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
        end
    end

    assign inst_sram_en    = r_ce;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'd0;
    assign if_to_id_bus    = {r_ce, r_pc};

    inst_hold_buf u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .stall_id (stall[c_STALL_ID]),
        .rdata_in (inst_sram_rdata),
        .inst_out (id_inst)
    );

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch
// Brief   : Self-checking bench for if_fetch (default and wrapping RESET_PC).
// Revision: 1.0
// ============================================================================
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [31:0] rdata;

    logic [32:0] bus_a, bus_b;
    logic        en_a, en_b;
    logic [3:0]  wen_a, wen_b;
    logic [31:0] addr_a, addr_b, wdata_a, wdata_b, id_a, id_b;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] c_rpc [2];
    logic [31:0] m_pc  [2];
    logic        m_ce;
    logic        m_s2_prev;
    logic [31:0] m_cap;

    always #5 clk = ~clk;

    if_fetch u_dut (
        .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
        .if_to_id_bus(bus_a), .inst_sram_en(en_a), .inst_sram_wen(wen_a),
        .inst_sram_addr(addr_a), .inst_sram_wdata(wdata_a),
        .inst_sram_rdata(rdata), .id_inst(id_a)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
        .if_to_id_bus(bus_b), .inst_sram_en(en_b), .inst_sram_wen(wen_b),
        .inst_sram_addr(addr_b), .inst_sram_wdata(wdata_b),
        .inst_sram_rdata(rdata), .id_inst(id_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: PC advances by 4 or jumps whenever IF is not stalled; ID sees
    // the word captured at the start of an ID stall for every cycle after a
    // stalled cycle, otherwise the live SRAM word.
    task automatic check_outputs();
        logic [31:0] exp_id;
        exp_id = m_s2_prev ? m_cap : rdata;
        chk("en_a",    {63'd0, en_a},   {63'd0, m_ce});
        chk("addr_a",  {32'd0, addr_a}, {32'd0, m_pc[0]});
        chk("bus_a",   {31'd0, bus_a},  {31'd0, m_ce, m_pc[0]});
        chk("en_b",    {63'd0, en_b},   {63'd0, m_ce});
        chk("addr_b",  {32'd0, addr_b}, {32'd0, m_pc[1]});
        chk("bus_b",   {31'd0, bus_b},  {31'd0, m_ce, m_pc[1]});
        chk("wen",     {56'd0, wen_a, wen_b}, 64'd0);
        chk("wdata",   {wdata_a, wdata_b}, 64'd0);
        chk("id_a",    {32'd0, id_a}, {32'd0, exp_id});
        chk("id_b",    {32'd0, id_b}, {32'd0, exp_id});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pc[0]   = c_rpc[0];
            m_pc[1]   = c_rpc[1];
            m_ce      = 1'b0;
            m_s2_prev = 1'b0;
        end else begin
            if (!stall[0]) begin
                for (int k = 0; k < 2; k++)
                    m_pc[k] = br_bus[32] ? br_bus[31:0] : m_pc[k] + 32'd4;
                m_ce = 1'b1;
            end
            if (stall[2] && !m_s2_prev) m_cap = rdata;
            m_s2_prev = stall[2];
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic [5:0] st, input logic [32:0] br,
                         input logic [31:0] rd);
        rst    = r;
        stall  = st;
        br_bus = br;
        rdata  = rd;
        #3;
        check_outputs();
    endtask

    initial begin
        logic [5:0]  st;
        logic [32:0] br;
        logic        r;
        c_rpc[0]  = 32'hBFBF_FFFC;
        c_rpc[1]  = 32'hFFFF_FFF8;
        m_pc[0]   = 32'd0;
        m_pc[1]   = 32'd0;
        m_ce      = 1'b0;
        m_s2_prev = 1'b0;
        m_cap     = 32'd0;
        rst = 1'b1; stall = 6'd0; br_bus = 33'd0; rdata = 32'd0;
        tick();

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'd0, 33'd0, $urandom);
            chk("rst_en", {63'd0, en_a}, 64'd0);
            tick();
        end
        drive(1'b0, 6'd0, 33'd0, $urandom);
        tick();
        drive(1'b0, 6'd0, 33'd0, $urandom);
        chk("boot0_a", {32'd0, addr_a}, 64'h0000_0000_BFC0_0000);
        chk("boot0_b", {32'd0, addr_b}, 64'h0000_0000_FFFF_FFFC);
        tick();
        drive(1'b0, 6'd0, 33'd0, $urandom);
        chk("boot1_a", {32'd0, addr_a}, 64'h0000_0000_BFC0_0004);
        chk("wrap_b",  {32'd0, addr_b}, 64'd0);
        tick();
        drive(1'b0, 6'd0, {1'b1, 32'hBFC0_0100}, $urandom);
        chk("boot2_a", {32'd0, addr_a}, 64'h0000_0000_BFC0_0008);
        chk("wrap1_b", {32'd0, addr_b}, 64'h0000_0000_0000_0004);
        tick();
        drive(1'b0, 6'd0, 33'd0, $urandom);
        chk("br_tgt", {32'd0, addr_a}, 64'h0000_0000_BFC0_0100);
        tick();
        drive(1'b0, 6'd0, 33'd0, $urandom);
        chk("br_seq", {32'd0, addr_a}, 64'h0000_0000_BFC0_0104);
        tick();

        // IF and ID stalled three cycles while SRAM data keeps changing
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 6'b000101, 33'd0, 32'h1111_1111 * i);
            chk("stl_id", {32'd0, id_a}, 64'h0000_0000_1111_1111);
            chk("stl_pc", {32'd0, addr_a}, 64'h0000_0000_BFC0_0108);
            tick();
        end
        drive(1'b0, 6'd0, 33'd0, 32'h4444_4444);
        chk("rel_id", {32'd0, id_a}, 64'h0000_0000_1111_1111);
        tick();
        drive(1'b0, 6'd0, 33'd0, 32'h5555_5555);
        chk("post_id", {32'd0, id_a}, 64'h0000_0000_5555_5555);
        chk("post_pc", {32'd0, addr_a}, 64'h0000_0000_BFC0_010C);
        tick();

        // Branch presented under IF stall is ignored until the stall drops
        drive(1'b0, 6'b000001, {1'b1, 32'hBFC0_0200}, $urandom);
        tick();
        drive(1'b0, 6'd0, {1'b1, 32'hBFC0_0200}, $urandom);
        chk("brstl_hold", {32'd0, addr_a}, 64'h0000_0000_BFC0_0110);
        tick();
        drive(1'b0, 6'd0, 33'd0, $urandom);
        chk("brstl_go", {32'd0, addr_a}, 64'h0000_0000_BFC0_0200);
        tick();

        // Reset while the hold buffer is holding
        drive(1'b0, 6'b000100, 33'd0, 32'hAAAA_0001);
        tick();
        drive(1'b1, 6'b000100, 33'd0, 32'hAAAA_0002);
        chk("hold_b4rst", {32'd0, id_a}, 64'h0000_0000_AAAA_0001);
        tick();
        drive(1'b1, 6'd0, 33'd0, 32'hAAAA_0003);
        chk("rst_pass", {32'd0, id_a}, 64'h0000_0000_AAAA_0003);
        chk("rst_pc",   {32'd0, addr_a}, 64'h0000_0000_BFBF_FFFC);
        tick();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            st = 6'($urandom);
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 2) != 0) st[b] = 1'b0;
            if (!m_ce) st[0] = 1'b0;
            br = {($urandom_range(0, 6) == 0), $urandom & 32'hFFFF_FFFC};
            drive(r, st, br, $urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_if_fetch
`default_nettype wire
